// File: rtl/rv_pkg.sv
// Shared loader types and constants.
// Imported by the loader top and its byte assembler.
package rv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 4-byte packer for the loader stream.
// word_next already contains the byte being accepted this cycle.
module byte_assembler
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt;

  always_comb begin
    word_next = word_q;
    word_next[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  assign word_ready = byte_en &&
    (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (byte_en) begin
      word_q   <= word_next;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory.
// Keeps the core in reset until the full image has been written.
module instr_mem_loader
  import rv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  ld_state_e   state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [15:0] n_full;
  logic        xfer;
  logic [31:0] asm_word;
  logic        asm_ready;

  assign xfer   = in_valid && in_ready;
  assign n_full = {in_data, len_q[7:0]};

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (xfer && state_q == ST_LEN_HI),
    .byte_en    (xfer && state_q == ST_DATA),
    .byte_in    (in_data),
    .word_next  (asm_word),
    .word_ready (asm_ready)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_d = ST_LEN_LO;
      ST_LEN_LO:
        if (xfer) state_d = ST_LEN_HI;
      ST_LEN_HI:
        if (xfer) begin
          if (n_full == 16'd0)
            state_d = ST_DONE;
          else if ({1'b0, n_full} > 17'(DEPTH_WORDS))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      ST_DATA:
        if (asm_ready) state_d = ST_WRITE;
      ST_WRITE:
        if (word_idx_q + 16'd1 == len_q)
          state_d = ST_DONE;
        else
          state_d = ST_DATA;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state_d so they land glitch-free
  // in the same cycle the state register does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LEN_LO && xfer)
        len_q[7:0] <= in_data;
      if (state_q == ST_LEN_HI && xfer) begin
        len_q[15:8] <= in_data;
        word_idx_q  <= '0;
      end
      if (state_q == ST_WRITE)
        word_idx_q <= word_idx_q + 16'd1;
      in_ready <= state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA};
      mem_we   <= (state_d == ST_WRITE);
      if (state_d == ST_WRITE) begin
        mem_addr  <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
        mem_wdata <= asm_word;
      end
      core_rst_n <= (state_d == ST_DONE);
      done       <= (state_d == ST_DONE);
      error      <= (state_d == ST_ERR);
      busy       <= state_d inside
        {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE};
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader.
// Expected writes come straight from the image word list.
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instr_mem_loader #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    while (gap > 0 && int'($urandom_range(99)) < gap && t < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic send_image(input logic [31:0] words[$],
                            input logic [15:0] n,
                            input int gap);
    pulse_start();
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    foreach (words[i]) send_word(words[i], gap);
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (!done && !error && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end"}, {31'b0, done | error}, 32'd1);
  endtask

  task automatic check_writes(input string tag,
                              input logic [31:0] words[$]);
    int n;
    check({tag, "_nwr"}, wr_addr_q.size(), words.size());
    n = (wr_addr_q.size() < words.size()) ? wr_addr_q.size()
                                          : words.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i],
            BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], words[i]);
    end
  endtask

  function automatic void rand_words(output logic [31:0] q[$],
                                     input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endfunction

  initial begin
    logic [31:0] img[$];
    int seen;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_flags", {29'b0, busy, done, error}, 32'd0);
    rst = 1'b1;

    // idle without start
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (in_ready || core_rst_n || busy) seen++;
    end
    check("idle_active", seen, 0);
    check("idle_writes", wr_addr_q.size(), 0);

    // directed N=2 image
    clear_log();
    img = '{32'h00A00513, 32'h00B00593};
    send_image(img, 16'd2, 0);
    check("n2_last_we", {31'b0, mem_we}, 32'd1);
    check("n2_done_early", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("n2_done", {31'b0, done}, 32'd1);
    check("n2_core_rst_n", {31'b0, core_rst_n}, 32'd1);
    check("n2_we_off", {31'b0, mem_we}, 32'd0);
    check_writes("n2", img);

    // N=0
    clear_log();
    img.delete();
    send_image(img, 16'd0, 0);
    check("n0_done", {31'b0, done}, 32'd1);
    check("n0_core_rst_n", {31'b0, core_rst_n}, 32'd1);
    repeat (3) @(negedge clk);
    check("n0_writes", wr_addr_q.size(), 0);

    // oversize length, then recovery
    clear_log();
    pulse_start();
    check("len_busy", {31'b0, busy}, 32'd1);
    check("len_core_held", {31'b0, core_rst_n}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("err_flag", {31'b0, error}, 32'd1);
    check("err_in_ready", {31'b0, in_ready}, 32'd0);
    check("err_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    repeat (5) @(negedge clk);
    check("err_sticky", {30'b0, error, busy}, 32'd2);
    check("err_writes", wr_addr_q.size(), 0);
    rand_words(img, 1);
    send_image(img, 16'd1, 0);
    wait_end("rec");
    check("rec_error", {31'b0, error}, 32'd0);
    check("rec_done", {31'b0, done}, 32'd1);
    check_writes("rec", img);

    // N=1024 accepted boundary: only the length phase is checked
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("max_len_ok", {30'b0, error, busy}, 32'd1);
    rst = 1'b0;
    #2;
    rst = 1'b1;

    // N=16, gap-free then gapped
    rand_words(img, 16);
    clear_log();
    send_image(img, 16'd16, 0);
    wait_end("g0");
    check_writes("g0", img);
    clear_log();
    send_image(img, 16'd16, 30);
    wait_end("g30");
    check_writes("g30", img);

    // asynchronous reset mid-load
    rand_words(img, 4);
    clear_log();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_word(img[0], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    check("mid_first_wr", wr_addr_q.size(), 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_mem_we", {31'b0, mem_we}, 32'd0);
    check("mid_mem_addr", mem_addr, BASE);
    check("mid_mem_wdata", mem_wdata, 32'd0);
    check("mid_flags", {28'b0, core_rst_n, busy, done, error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_rst_n || in_ready) seen++;
    end
    check("mid_held", seen, 0);
    clear_log();
    send_image(img, 16'd4, 20);
    wait_end("mid_reload");
    check("mid_reload_core", {31'b0, core_rst_n}, 32'd1);
    check_writes("mid_reload", img);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time program loader upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 16-bit little-endian word count N, then N little-endian 32-bit instruction words.
- Writes each word into instruction memory.
- Holds the core in reset until the image is complete, then releases it.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words; N > DEPTH_WORDS is an error.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  32  byte address, BASE_ADDR + 4*word_idx
- mem_wdata  out  32  assembled instruction word
- core_rst_n  out  1  active-low reset to core; 0 = core held
- busy  out  1  load in progress
- done  out  1  image loaded, core released
- error  out  1  length rejected

Behaviour:
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all counters clear.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_rst_n=0, busy=0, done=0, error=0.
- Byte transfer occurs only when in_valid && in_ready on a rising edge. in_ready=1 only in LEN_LO, LEN_HI and DATA (registered from state, no combinational path from in_valid).
- IDLE: start -> LEN_LO.
- LEN_LO: transfer captures N[7:0] -> LEN_HI.
- LEN_HI: transfer captures N[15:8]; the next state uses the full N (byte just accepted included):
  - N==0 -> DONE
  - N>DEPTH_WORDS -> ERR
  - otherwise DATA, with word_idx=0 and byte_cnt=0.
- DATA: each transfer places the byte at bits [8*byte_cnt+7 : 8*byte_cnt] of the assembly register, then byte_cnt increments (2-bit, wraps). The 4th byte (byte_cnt==3) -> WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr=BASE_ADDR+{word_idx,2'b00}, mem_wdata=assembled word, in_ready=0.
  - Then word_idx increments; word_idx+1==N -> DONE, else -> DATA.
  - Write-to-first-byte-of-next-word latency: stream sees one idle cycle per word.
- DONE: core_rst_n=1, done=1. start -> LEN_LO with core_rst_n=0 and done=0 on the next edge (reload).
- ERR: error=1, core_rst_n=0. Only start (-> LEN_LO, error cleared) or rst leaves ERR.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE. start is ignored while busy.
- Stream stalls: in_valid low in any receive state simply holds state; there is no timeout.
- mem_addr/mem_wdata hold their last value outside WRITE; the memory must qualify on mem_we only.
- core_rst_n and all outputs are registered: glitch-free, change only on clk edges or asynchronous rst assertion.
- Reset mid-load: words already written stay in memory (no rollback); core stays held; a new start is required.
- Width: word_idx is 16 bits; mem_addr arithmetic is 32-bit modulo, no overflow check beyond the DEPTH_WORDS limit.

Decomposition:
- Shared package (rv_pkg): loader state encoding (3-bit enum), LEN_BYTES=2, WORD_BYTES=4.
- One natural sub-module: byte_assembler, the 4-byte little-endian shift/pack with byte_cnt and a word_ready flag. The FSM and counters remain in instr_mem_loader.

Test Plan:
- Reset then idle -> core_rst_n=0, in_ready=0, mem_we never asserted for 100 cycles without start.
- Load N=2: start, bytes 02 00 13 05 A0 00 93 05 B0 00 ->
  - write 0x00A00513 @0x0, then 0x00B00593 @0x4, one mem_we each;
  - done=1 and core_rst_n=1 the cycle after the second WRITE.
- N=0: start, bytes 00 00 -> DONE immediately, no mem_we, core_rst_n=1.
- N=1025 with DEPTH_WORDS=1024: bytes 01 04 -> error=1, in_ready=0, core_rst_n=0; a subsequent start plus valid 1-word image clears error and loads.
- Random in_valid gaps (30% duty) over N=16 -> identical memory contents and addresses 0x0..0x3C as the gap-free run.
- rst asserted after 6 data bytes of N=4 -> outputs return to reset values immediately (asynchronously); after deassertion the core stays held until a full reload completes.
